line_compositor: RTL
====================

Name: line_compositor

Overview:
- Write-side stage directly upstream of frame_buffer.
- Once per scanline, on a row_start pulse, it sweeps the write X counter across the active line for the next line's Y.
- For each pixel it queries the sprite drawers' hit flags, selects the top-priority layer's ROM address, absorbs the spriteROM read latency, resolves transparency, and emits one colour-index write per pixel.
- It owns double-buffer select toggling and replaces the free-running WriteX/WriteY counters in color_mapper.

Parameters:
- H_ACTIVE, 640, pixels written per line (X = 0..H_ACTIVE-1).
- V_LINES, 525, line count; line_y wraps at V_LINES-1.
- ROM_LAT, 1, spriteROM read latency in cycles (1..3 supported).
- TRANSP_IDX, 4'h0, colour index treated as transparent.
- BG_IDX, 4'hF, index written when no layer hits or the hit pixel is transparent.

Ports:
- Clk50  in  1  system clock (50 MHz)
- Reset_n  in  1  asynchronous active-low reset
- row_start  in  1  one-cycle pulse, synchronous to Clk50, at the start of each display row
- hit  in  4  layer hit flags for (query_x, query_y); [3]=runner, [2]=score, [1]=cloud, [0]=horizon
- addr_runner, addr_score, addr_cloud, addr_horizon  in  18 each  ROM address for each layer at the query pixel
- rom_data  in  4  spriteROM data_Out
- query_x, query_y  out  10 each  pixel currently being queried
- rom_addr  out  18  spriteROM read_address
- wr_en  out  1  frame_buffer write enable
- wr_x, wr_y  out  10 each  write coordinates
- wr_data  out  4  colour index to write
- buf_select  out  1  frame_buffer select
- busy  out  1  high from sweep start until the last write
- line_done  out  1  one-cycle pulse on the last write of a line
- overrun  out  1  one-cycle pulse when row_start arrives while busy

Behaviour:
- Reset (async, Reset_n=0):
  - state IDLE.
  - query_x=0, query_y=0, wr_en=0, wr_x=0, wr_y=0, wr_data=BG_IDX.
  - buf_select=0, busy=0, line_done=0, overrun=0.
  - Pipeline valid bits cleared.
  - Release is synchronous to the next Clk50 edge.
- States: IDLE, SWEEP, DRAIN.
- IDLE + row_start:
  - buf_select toggles.
  - query_y advances by one; it wraps V_LINES-1 -> 0.
  - query_x=0; go to SWEEP; busy=1.
- SWEEP: query_x increments once per cycle. On the cycle where query_x=H_ACTIVE-1, go to DRAIN.
- DRAIN: lasts exactly ROM_LAT cycles, then returns to IDLE. The last write occurs in the final DRAIN cycle, with line_done=1 in that cycle.
- Layer select (combinational from hit):
  - Priority is runner > score > cloud > horizon.
  - rom_addr is the selected layer's address.
  - If hit=0, rom_addr=20 and sel_valid=0.
- Pipeline: query_x, query_y and sel_valid are delayed ROM_LAT stages. Query of X=k in cycle t produces a write of X=k in cycle t+ROM_LAT.
- Write data:
  - wr_data = rom_data if sel_valid and rom_data != TRANSP_IDX; otherwise BG_IDX.
  - wr_en is high only for delayed-valid pixels: exactly H_ACTIVE writes per line, never outside 0..H_ACTIVE-1.
- row_start while busy:
  - Ignored; the current line completes unchanged.
  - overrun pulses for one cycle.
  - buf_select does not toggle.
- row_start coincident with the final DRAIN cycle counts as while busy: overrun, ignored.
- Reset mid-sweep: outputs return to reset values immediately; no partial write is completed.

Optional Feature:
- Macro LINE_COMPOSITOR_BORDER_EN.
- When defined: pixels with write X=0, X=H_ACTIVE-1, Y=0 or Y=479 are written as 4'h1 regardless of layers (alignment debug).
- When undefined: no override; the logic is absent.

Decomposition:
- Shared package sprite_pkg holds:
  - layer_e enum (RUNNER, SCORE, CLOUD, HORIZON)
  - H_ACTIVE_C, V_LINES_C, TRANSP_IDX_C, BG_IDX_C, DEFAULT_ADDR_C (18'd20)
  - the pixel pipeline struct {x, y, valid}
- One sub-module, layer_priority_sel: combinational hit/addr to (rom_addr, sel_valid). It is reusable by a future read-side collision detector.

Test Plan:
- Single line, ROM_LAT=1, hit=0 throughout:
  - exactly 640 wr_en cycles; wr_x 0..639 consecutive; wr_data=4'hF.
  - line_done at wr_x=639; buf_select toggled once.
- hit=4'b1010, addr_runner=1000, rom_data=4'h3 at X=100: rom_addr=1000 at query X=100; wr_x=100 one cycle later with wr_data=4'h3.
- Same pixel with rom_data=4'h0: wr_data=4'hF.
- row_start pulsed at sweep cycle 300: overrun=1 for one cycle; the line still ends at X=639; buf_select unchanged.
- query_y starting at 524, then row_start: query_y=0 and wr_y=0 on all writes of that line.
- Reset_n low at X=200, held 3 cycles, then released:
  - wr_en=0, busy=0, buf_select=0 immediately.
  - The next row_start restarts at X=0 with query_y=1.
  - With LINE_COMPOSITOR_BORDER_EN defined, wr_data=4'h1 at X=0 and X=639.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite/compositor types and constants.
// Imported by line_compositor and layer_priority_sel.
package sprite_pkg;

  typedef enum logic [1:0] {
    RUNNER,
    SCORE,
    CLOUD,
    HORIZON
  } layer_e;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN
  } lc_state_e;

  localparam int          H_ACTIVE_C     = 640;
  localparam int          V_LINES_C      = 525;
  localparam logic [3:0]  TRANSP_IDX_C   = 4'h0;
  localparam logic [3:0]  BG_IDX_C       = 4'hF;
  localparam logic [17:0] DEFAULT_ADDR_C = 18'd20;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       valid;
  } pix_t;

endpackage

// File: rtl/line_compositor_layer_priority_sel.sv
// Layer priority select: runner > score > cloud > horizon.
// Purely combinational; shared with the read-side collision path.
module layer_priority_sel
  import sprite_pkg::*;
(
  input  logic [3:0]  hit,
  input  logic [17:0] addr_runner,
  input  logic [17:0] addr_score,
  input  logic [17:0] addr_cloud,
  input  logic [17:0] addr_horizon,
  output logic [17:0] rom_addr,
  output logic        sel_valid
);

  layer_e layer;

  always_comb begin
    layer     = HORIZON;
    sel_valid = 1'b1;
    priority case (1'b1)
      hit[3]:  layer = RUNNER;
      hit[2]:  layer = SCORE;
      hit[1]:  layer = CLOUD;
      hit[0]:  layer = HORIZON;
      default: sel_valid = 1'b0;
    endcase
  end

  always_comb begin
    rom_addr = DEFAULT_ADDR_C;
    if (sel_valid) begin
      unique case (layer)
        RUNNER:  rom_addr = addr_runner;
        SCORE:   rom_addr = addr_score;
        CLOUD:   rom_addr = addr_cloud;
        HORIZON: rom_addr = addr_horizon;
        default: rom_addr = DEFAULT_ADDR_C;
      endcase
    end
  end

endmodule

// File: rtl/line_compositor.sv
// Per-scanline write sweep into frame_buffer with sprite layering.
// Optional macro LINE_COMPOSITOR_BORDER_EN paints a debug border (index 1).
module line_compositor
  import sprite_pkg::*;
#(
  parameter int         H_ACTIVE   = H_ACTIVE_C,
  parameter int         V_LINES    = V_LINES_C,
  parameter int         ROM_LAT    = 1,
  parameter logic [3:0] TRANSP_IDX = TRANSP_IDX_C,
  parameter logic [3:0] BG_IDX     = BG_IDX_C
)(
  input  logic        Clk50,
  input  logic        Reset_n,
  input  logic        row_start,
  input  logic [3:0]  hit,
  input  logic [17:0] addr_runner,
  input  logic [17:0] addr_score,
  input  logic [17:0] addr_cloud,
  input  logic [17:0] addr_horizon,
  input  logic [3:0]  rom_data,
  output logic [9:0]  query_x,
  output logic [9:0]  query_y,
  output logic [17:0] rom_addr,
  output logic        wr_en,
  output logic [9:0]  wr_x,
  output logic [9:0]  wr_y,
  output logic [3:0]  wr_data,
  output logic        buf_select,
  output logic        busy,
  output logic        line_done,
  output logic        overrun
);

  lc_state_e state, state_n;
  logic [9:0] qx, qx_n;
  logic [9:0] qy, qy_n;
  logic       bsel, bsel_n;
  logic [1:0] dcnt, dcnt_n;
  logic       sel_valid;

  pix_t [ROM_LAT-1:0] pipe;
  logic [ROM_LAT-1:0] sel_d;
  pix_t               last;

  layer_priority_sel u_sel (
    .hit          (hit),
    .addr_runner  (addr_runner),
    .addr_score   (addr_score),
    .addr_cloud   (addr_cloud),
    .addr_horizon (addr_horizon),
    .rom_addr     (rom_addr),
    .sel_valid    (sel_valid)
  );

  always_comb begin
    state_n = state;
    qx_n    = qx;
    qy_n    = qy;
    bsel_n  = bsel;
    dcnt_n  = dcnt;
    unique case (state)
      IDLE: begin
        if (row_start) begin
          bsel_n  = ~bsel;
          qy_n    = (qy == 10'(V_LINES - 1)) ? 10'd0
                                             : qy + 10'd1;
          qx_n    = 10'd0;
          state_n = SWEEP;
        end
      end
      SWEEP: begin
        if (qx == 10'(H_ACTIVE - 1)) begin
          state_n = DRAIN;
          dcnt_n  = 2'd0;
        end else begin
          qx_n = qx + 10'd1;
        end
      end
      DRAIN: begin
        if (dcnt == 2'(ROM_LAT - 1)) state_n = IDLE;
        else                         dcnt_n  = dcnt + 2'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk50 or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      qx    <= '0;
      qy    <= '0;
      bsel  <= 1'b0;
      dcnt  <= '0;
    end else begin
      state <= state_n;
      qx    <= qx_n;
      qy    <= qy_n;
      bsel  <= bsel_n;
      dcnt  <= dcnt_n;
    end
  end

  // Delay line matches the spriteROM read latency.
  always_ff @(posedge Clk50 or negedge Reset_n) begin
    if (!Reset_n) begin
      pipe  <= '0;
      sel_d <= '0;
    end else begin
      pipe[0]  <= '{x: qx, y: qy, valid: (state == SWEEP)};
      sel_d[0] <= sel_valid;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe[i]  <= pipe[i-1];
        sel_d[i] <= sel_d[i-1];
      end
    end
  end

  assign last = pipe[ROM_LAT-1];

  always_comb begin
    wr_data = BG_IDX;
    if (sel_d[ROM_LAT-1] && rom_data != TRANSP_IDX)
      wr_data = rom_data;
`ifdef LINE_COMPOSITOR_BORDER_EN
    if (last.valid &&
        (last.x == 10'd0 ||
         last.x == 10'(H_ACTIVE - 1) ||
         last.y == 10'd0 ||
         last.y == 10'd479))
      wr_data = 4'h1;
`endif
  end

  assign query_x    = qx;
  assign query_y    = qy;
  assign wr_en      = last.valid;
  assign wr_x       = last.x;
  assign wr_y       = last.y;
  assign buf_select = bsel;
  assign busy       = (state != IDLE);
  assign line_done  = (state == DRAIN) &&
                      (dcnt == 2'(ROM_LAT - 1));
  assign overrun    = row_start && busy;

endmodule
